mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data BRAM (19-bit word address, 32-bit data, byte write enables) between the exec unit and a second requester such as the UART program loader. It accepts one access per cycle, registers the selected command onto the BRAM port, and tracks the owner of every in-flight read. It then returns `rvalid` to the correct port exactly `RD_LAT` cycles after issue. It sits between exec/loader and the BRAM primitive.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_arbiter_tagpipe.sv | 27 ++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-BRAM arbiter: bus widths, port indices
// and the read-ownership tag carried alongside every in-flight access.
package mem_pkg;

  localparam int MEM_AW = 19;
  localparam int MEM_DW = 32;
  localparam int MEM_BE = 4;

  localparam logic PORT_EXEC = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_tagpipe.sv
// RD_LAT-deep shift register of read tags; the last stage lines up with the
// BRAM read data. Async clear drops every in-flight read.
module mem_arbiter_tagpipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port data BRAM. Conflicts go to the
// exec port, or round-robin when MEM_ARBITER_RR_EN is defined.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic [MEM_BE-1:0] we0,
  input  logic [MEM_AW-1:0] addr0,
  input  logic [MEM_DW-1:0] wdata0,
  input  logic              req1,
  input  logic [MEM_BE-1:0] we1,
  input  logic [MEM_AW-1:0] addr1,
  input  logic [MEM_DW-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [MEM_DW-1:0] rdata,
  output logic              mem_enable,
  output logic [MEM_BE-1:0] mem_wea,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic [MEM_DW-1:0] mem_rdata
);

  // Handshake: a requester holds req/we/addr/wdata until it sees gnt; the
  // request is ignored in its own gnt cycle so a held req never issues twice.
  logic    elig0, elig1, pick1, issue;
  rd_tag_t tag_in, tag_out;

`ifdef MEM_ARBITER_RR_EN
  logic last1;  // port granted most recently; resets to 1 so exec wins first

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      last1 <= PORT_LOAD;
    else if (issue) last1 <= pick1;
  end
`endif

  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    issue = elig0 | elig1;
`ifdef MEM_ARBITER_RR_EN
    pick1 = elig1 & (~elig0 | ~last1);
`else
    pick1 = elig1 & ~elig0;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      mem_enable <= 1'b0;
      mem_wea    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt0       <= issue & ~pick1;
      gnt1       <= pick1;
      mem_enable <= issue;
      mem_wea    <= '0;
      if (issue) begin
        mem_wea   <= pick1 ? we1    : we0;
        mem_addr  <= pick1 ? addr1  : addr0;
        mem_wdata <= pick1 ? wdata1 : wdata0;
      end
    end
  end

  // Tag enters the pipe as the BRAM samples the command, so its last stage
  // coincides with valid mem_rdata.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = mem_enable & (mem_wea == '0);
    tag_in.port  = gnt1;
  end

  mem_arbiter_tagpipe #(.RD_LAT(RD_LAT)) u_tagpipe (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rvalid0 = tag_out.valid & (tag_out.port == PORT_EXEC);
  assign rvalid1 = tag_out.valid & (tag_out.port == PORT_LOAD);
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: read-first BRAM model, reference memory, and
// scoreboard queues for grants and read responses.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int NS     = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1;
  logic [3:0]  we0, we1;
  logic [18:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic        mem_enable;
  logic [3:0]  mem_wea;
  logic [18:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_enable(mem_enable), .mem_wea(mem_wea),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read-first BRAM behind the arbiter
  logic [31:0] bram [logic [18:0]];
  logic [31:0] rd_pipe [RD_LAT];
  logic [31:0] bram_w;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_enable) begin
      rd_pipe[0] <= bram.exists(mem_addr) ? bram[mem_addr] : 32'h0;
      if (mem_wea != 4'h0) begin
        bram_w = merge(bram.exists(mem_addr) ? bram[mem_addr] : 32'h0, mem_wea, mem_wdata);
        bram[mem_addr] = bram_w;
      end
    end
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Scoreboard: exp_gnt_q = {port, we, addr, wdata}; exp_q = {port, data}
  logic [31:0] ref_mem [logic [18:0]];
  logic [55:0] exp_gnt_q [$];
  logic [32:0] exp_q [$];
  int          issue_cyc_q [$];
  int          last_gnt = 1;

  task automatic preload(input logic [18:0] a, input logic [31:0] d);
    bram[a]    = d;
    ref_mem[a] = d;
  endtask

  task automatic expect_access(input int p, input logic [3:0] we, input logic [18:0] a,
                               input logic [31:0] d, input bit want_rsp);
    logic [31:0] old;
    logic        pb;
    pb  = (p != 0);
    old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    exp_gnt_q.push_back({pb, we, a, d});
    if (we == 4'h0) begin
      if (want_rsp) exp_q.push_back({pb, old});
    end else begin
      ref_mem[a] = merge(old, we, d);
    end
    last_gnt = p;
  endtask

  function automatic int conflict_winner();
`ifdef MEM_ARBITER_RR_EN
    return (last_gnt == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic issue(input int p, input logic [3:0] we, input logic [18:0] a,
                       input logic [31:0] d, input bit hold);
    int n;
    bit got;
    @(posedge clk); #1;
    if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      got = (p == 0) ? gnt0 : gnt1;
    end
    if (!got) check("gnt_timeout", 64'd0, 64'd1);
    if (hold) begin @(posedge clk); #1; end
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [55:0] eg;
    logic [32:0] er;
    if (rstn === 1'b1) begin
      if (gnt0 || gnt1) begin
        check("gnt_onehot", gnt0 & gnt1, 0);
        check("gnt_pending", exp_gnt_q.size() > 0, 1);
        if (exp_gnt_q.size() > 0) begin
          eg = exp_gnt_q.pop_front();
          check("gnt_port", gnt1, eg[55]);
          check("mem_enable", mem_enable, 1);
          check("mem_wea", mem_wea, eg[54:51]);
          check("mem_addr", mem_addr, eg[50:32]);
          if (eg[54:51] != 4'h0) check("mem_wdata", mem_wdata, eg[31:0]);
          else issue_cyc_q.push_back(cyc);
        end
      end else begin
        check("idle_enable", mem_enable, 0);
        check("idle_wea", mem_wea, 0);
      end
      if (rvalid0 || rvalid1) begin
        check("rvalid_onehot", rvalid0 & rvalid1, 0);
        check("rsp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          er = exp_q.pop_front();
          check("rv_port", rvalid1, er[32]);
          check("rdata", rdata, er[31:0]);
          if (issue_cyc_q.size() > 0) check("rd_latency", cyc - issue_cyc_q.pop_front(), RD_LAT);
        end
      end
    end
  end

  logic [3:0]  s_we   [2][NS];
  logic [18:0] s_addr [2][NS];
  logic [31:0] s_wd   [2][NS];

  task automatic stream(input int p);
    for (int i = 0; i < NS; i++) issue(p, s_we[p][i], s_addr[p][i], s_wd[p][i], 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {gnt1, gnt0}, 0);
    check({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    check({tag, "_enable"}, mem_enable, 0);
    check({tag, "_wea"}, mem_wea, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic conflict_pair(input logic [18:0] a0, input logic [18:0] a1);
    int w;
    w = conflict_winner();
    if (w == 0) begin
      expect_access(0, 4'h0, a0, 32'h0, 1'b1);
      expect_access(1, 4'h0, a1, 32'h0, 1'b1);
    end else begin
      expect_access(1, 4'h0, a1, 32'h0, 1'b1);
      expect_access(0, 4'h0, a0, 32'h0, 1'b1);
    end
    fork
      issue(0, 4'h0, a0, 32'h0, 1'b0);
      issue(1, 4'h0, a1, 32'h0, 1'b0);
    join
  endtask

  initial begin
    int first;
    rstn = 1'b0;
    req0 = 1'b0; we0 = '0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = '0; addr1 = '0; wdata1 = '0;
    preload(19'h00010, 32'hDEADBEEF);
    preload(19'h00004, 32'h11223344);
    preload(19'h00030, 32'h0BADF00D);
    preload(19'h00040, 32'h40404040);
    preload(19'h00041, 32'h41414141);
    preload(19'h7FFFF, 32'hCAFEF00D);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NS; i++) begin
        s_addr[p][i] = 19'h00100 + 19'(p * 256 + i);
        preload(s_addr[p][i], $urandom);
        s_we[p][i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        s_wd[p][i] = $urandom;
      end
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rstn = 1'b1;

    // Single exec read
    expect_access(0, 4'h0, 19'h00010, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h00010, 32'h0, 1'b0);
    repeat (4) @(posedge clk);

    // Loader byte write, then exec reads the merged word
    expect_access(1, 4'b0010, 19'h00004, 32'h0000AB00, 1'b1);
    issue(1, 4'b0010, 19'h00004, 32'h0000AB00, 1'b0);
    expect_access(0, 4'h0, 19'h00004, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h00004, 32'h0, 1'b0);
    repeat (4) @(posedge clk);

    // Read then write of the same word in consecutive issue cycles
    expect_access(0, 4'h0, 19'h00030, 32'h0, 1'b1);
    expect_access(1, 4'hF, 19'h00030, 32'h12345678, 1'b1);
    fork
      issue(0, 4'h0, 19'h00030, 32'h0, 1'b0);
      begin @(posedge clk); issue(1, 4'hF, 19'h00030, 32'h12345678, 1'b0); end
    join
    expect_access(0, 4'h0, 19'h00030, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h00030, 32'h0, 1'b0);
    repeat (4) @(posedge clk);

    // req held through the gnt cycle issues once
    expect_access(0, 4'h0, 19'h00010, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h00010, 32'h0, 1'b1);
    repeat (4) @(posedge clk);

    // Simultaneous conflict decided by policy
    conflict_pair(19'h00040, 19'h00041);
    repeat (4) @(posedge clk);

    // Both ports streaming
    first = conflict_winner();
    for (int i = 0; i < NS; i++) begin
      expect_access(first, s_we[first][i], s_addr[first][i], s_wd[first][i], 1'b1);
      expect_access(1 - first, s_we[1-first][i], s_addr[1-first][i], s_wd[1-first][i], 1'b1);
    end
    fork
      stream(0);
      stream(1);
    join
    repeat (4) @(posedge clk);

    // Top address: read, full write, read back
    expect_access(0, 4'h0, 19'h7FFFF, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h7FFFF, 32'h0, 1'b0);
    expect_access(1, 4'hF, 19'h7FFFF, 32'hA5A55A5A, 1'b1);
    issue(1, 4'hF, 19'h7FFFF, 32'hA5A55A5A, 1'b0);
    expect_access(0, 4'h0, 19'h7FFFF, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h7FFFF, 32'h0, 1'b0);
    repeat (4) @(posedge clk);

    // Reset right after the third of three reads; its response must vanish
    expect_access(0, 4'h0, 19'h00010, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h00010, 32'h0, 1'b0);
    expect_access(0, 4'h0, 19'h00004, 32'h0, 1'b1);
    issue(0, 4'h0, 19'h00004, 32'h0, 1'b0);
    expect_access(0, 4'h0, 19'h00030, 32'h0, 1'b0);
    issue(0, 4'h0, 19'h00030, 32'h0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst_gnt_drained", exp_gnt_q.size(), 0);
    check("midrst_rsp_drained", exp_q.size(), 0);
    issue_cyc_q.delete();
    last_gnt = 1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (RD_LAT + 6) @(posedge clk);

    // Pointer back at its reset value: exec wins the first conflict
    conflict_pair(19'h00040, 19'h00041);
    repeat (RD_LAT + 6) @(posedge clk);

    check("end_gnt_q_empty", exp_gnt_q.size(), 0);
    check("end_rsp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
